// File: rtl/md_seq_ctrl_if.sv
// Pipeline <-> multiply/divide sequencer bundle.
// Master is the execute-stage side; slave is md_seq_ctrl.
interface md_seq_ctrl_if #(
  parameter int PERF_W = 16
);
  logic              MdValidE;
  logic              MdIsDivE;
  logic [4:0]        RD_E;
  logic              AbortE;
  logic              MdStart;
  logic              MdAbort;
  logic              StallMD;
  logic              BubbleM_MD;
  logic              MdWbValid;
  logic [4:0]        MdRd;
  logic              MdBusy;
  logic [PERF_W-1:0] MdStallCnt;

  modport master (
    output MdValidE, MdIsDivE, RD_E, AbortE,
    input  MdStart, MdAbort, StallMD, BubbleM_MD,
    input  MdWbValid, MdRd, MdBusy, MdStallCnt
  );

  modport slave (
    input  MdValidE, MdIsDivE, RD_E, AbortE,
    output MdStart, MdAbort, StallMD, BubbleM_MD,
    output MdWbValid, MdRd, MdBusy, MdStallCnt
  );
endinterface

// File: rtl/md_seq_ctrl.sv
// Sequencer for the iterative MDU: starts the op in E, stalls the
// front end until done, then emits a one-cycle writeback strobe.
module md_seq_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 16
) (
  input logic            clk,
  input logic            rst,
  md_seq_ctrl_if.slave   md
);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic start, abort, stall, wb;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    start   = 1'b0;
    abort   = 1'b0;
    stall   = 1'b0;
    wb      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (md.MdValidE && !md.AbortE) begin
          start   = 1'b1;
          stall   = 1'b1;
          cnt_d   = md.MdIsDivE ? DIV_LD : MUL_LD;
          rd_d    = md.RD_E;
          state_d = RUN;
        end
      end
      RUN: begin
        if (md.AbortE) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        // Same op still sits in E here; it must not restart.
        state_d = IDLE;
        if (md.AbortE) begin
          abort = 1'b1;
        end else begin
          wb = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    perf_d = perf_q;
    if (stall && !rst && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      perf_q  <= perf_d;
    end
  end

  // The MDU has its own reset, so no pulse may escape during rst.
  assign md.MdStart    = start & ~rst;
  assign md.MdAbort    = abort & ~rst;
  assign md.StallMD    = stall & ~rst;
  assign md.BubbleM_MD = stall & ~rst;
  assign md.MdWbValid  = wb & ~rst;
  assign md.MdBusy     = (state_q == RUN) & ~rst;
  assign md.MdRd       = rd_q;
  assign md.MdStallCnt = perf_q;
endmodule

// File: tb/tb_md_seq_ctrl.sv
// Scoreboard bench for md_seq_ctrl: stimulus pushes expected
// writebacks, a negedge monitor pops and compares them.
module tb_md_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_seq_ctrl_if #(.PERF_W(16)) m_if ();
  md_seq_ctrl_if #(.PERF_W(4))  s_if ();

  md_seq_ctrl #(
    .MUL_CYCLES(4), .DIV_CYCLES(32),
    .CNT_W(6), .PERF_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .md(m_if.slave)
  );

  md_seq_ctrl #(
    .MUL_CYCLES(4), .DIV_CYCLES(32),
    .CNT_W(6), .PERF_W(4)
  ) u_sat (
    .clk(clk), .rst(rst), .md(s_if.slave)
  );

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] rd;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_if.MdWbValid) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_rd", {27'd0, m_if.MdRd}, {27'd0, mon_e.rd});
        chk("wb_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic isdiv,
                        input logic [4:0] rd,
                        input int n);
    m_if.MdValidE = 1'b1;
    m_if.MdIsDivE = isdiv;
    m_if.RD_E     = rd;
    m_if.AbortE   = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      if (k == 0) sb.push_back('{rd, cyc + n + 1});
      chk("stall", {31'd0, m_if.StallMD}, {31'd0, k <= n});
      chk("bubble", {31'd0, m_if.BubbleM_MD}, {31'd0, k <= n});
      chk("start", {31'd0, m_if.MdStart}, {31'd0, k == 0});
      chk("busy", {31'd0, m_if.MdBusy},
          {31'd0, (k >= 1) && (k <= n)});
      if (k == n + 1) begin
        exp_cnt += n + 1;
        chk("stall_cnt", {16'd0, m_if.MdStallCnt}, exp_cnt);
      end
      tick();
    end
  endtask

  task automatic go_idle;
    m_if.MdValidE = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_if.MdValidE = 1'b0;
    m_if.MdIsDivE = 1'b0;
    m_if.RD_E     = 5'd0;
    m_if.AbortE   = 1'b0;
    s_if.MdValidE = 1'b1;
    s_if.MdIsDivE = 1'b1;
    s_if.RD_E     = 5'd3;
    s_if.AbortE   = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", {31'd0, m_if.MdBusy}, 32'd0);
    chk("rst_rd", {27'd0, m_if.MdRd}, 32'd0);
    chk("rst_cnt", {16'd0, m_if.MdStallCnt}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_start", {31'd0, m_if.MdStart}, 32'd0);
    chk("post_rst_abort", {31'd0, m_if.MdAbort}, 32'd0);
    chk("post_rst_wb", {31'd0, m_if.MdWbValid}, 32'd0);
    tick();

    run_op(1'b0, 5'd5, 4);
    go_idle();
    run_op(1'b1, 5'd31, 32);
    go_idle();
    run_op(1'b0, 5'd9, 4);
    run_op(1'b1, 5'd12, 32);
    go_idle();
    run_op(1'b0, 5'd0, 4);
    go_idle();

    // Abort a divide in RUN at t10.
    m_if.MdValidE = 1'b1;
    m_if.MdIsDivE = 1'b1;
    m_if.RD_E     = 5'd17;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("ab_stall", {31'd0, m_if.StallMD}, 32'd1);
      tick();
    end
    m_if.AbortE = 1'b1;
    @(negedge clk);
    chk("ab_abort", {31'd0, m_if.MdAbort}, 32'd1);
    chk("ab_stall10", {31'd0, m_if.StallMD}, 32'd0);
    chk("ab_wb", {31'd0, m_if.MdWbValid}, 32'd0);
    exp_cnt += 10;
    tick();
    m_if.AbortE   = 1'b0;
    m_if.MdValidE = 1'b0;
    @(negedge clk);
    chk("ab_busy11", {31'd0, m_if.MdBusy}, 32'd0);
    chk("ab_abort11", {31'd0, m_if.MdAbort}, 32'd0);
    chk("ab_cnt", {16'd0, m_if.MdStallCnt}, exp_cnt);
    tick();

    // Abort a multiply in its DONE cycle.
    m_if.MdValidE = 1'b1;
    m_if.MdIsDivE = 1'b0;
    m_if.RD_E     = 5'd21;
    repeat (5) tick();
    m_if.AbortE = 1'b1;
    @(negedge clk);
    chk("dab_wb", {31'd0, m_if.MdWbValid}, 32'd0);
    chk("dab_abort", {31'd0, m_if.MdAbort}, 32'd1);
    chk("dab_stall", {31'd0, m_if.StallMD}, 32'd0);
    exp_cnt += 5;
    tick();
    m_if.AbortE   = 1'b0;
    m_if.MdValidE = 1'b0;
    tick();

    // Reset at t3 of a multiply.
    m_if.MdValidE = 1'b1;
    m_if.RD_E     = 5'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rs_stall", {31'd0, m_if.StallMD}, 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_if.MdValidE = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("rs_stall4", {31'd0, m_if.StallMD}, 32'd0);
    chk("rs_busy4", {31'd0, m_if.MdBusy}, 32'd0);
    chk("rs_start4", {31'd0, m_if.MdStart}, 32'd0);
    chk("rs_wb4", {31'd0, m_if.MdWbValid}, 32'd0);
    chk("rs_abort4", {31'd0, m_if.MdAbort}, 32'd0);
    chk("rs_rd4", {27'd0, m_if.MdRd}, 32'd0);
    chk("rs_cnt4", {16'd0, m_if.MdStallCnt}, 32'd0);
    tick();
    run_op(1'b0, 5'd7, 4);
    go_idle();

    repeat (40) tick();
    @(negedge clk);
    chk("sat_a", {28'd0, s_if.MdStallCnt}, 32'd15);
    repeat (20) tick();
    @(negedge clk);
    chk("sat_b", {28'd0, s_if.MdStallCnt}, 32'd15);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
